// File: rtl/riv_async_fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: user write port, RAM write port,
// pointer-transfer handshake to the CDC block and the returned read pointer.
interface riv_async_fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_en;
  logic                  wr_full;
  logic                  wr_almost_full;
  logic [ADDR_WIDTH-1:0] wr_count;
  logic                  wr_overflow;
  logic                  mem_we;
  logic [ADDR_WIDTH-2:0] mem_waddr;
  logic                  wr_fsm_load;
  logic                  wr_fsm_req_ack;
  logic                  wr_fsm_recv_ack;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr_wr;

  // Controller side
  modport master (
    input  wr_en,
    input  wr_fsm_recv_ack,
    input  raddr_wr,
    output wr_full,
    output wr_almost_full,
    output wr_count,
    output wr_overflow,
    output mem_we,
    output mem_waddr,
    output wr_fsm_load,
    output wr_fsm_req_ack,
    output waddr
  );

  // User / RAM / CDC side
  modport slave (
    output wr_en,
    output wr_fsm_recv_ack,
    output raddr_wr,
    input  wr_full,
    input  wr_almost_full,
    input  wr_count,
    input  wr_overflow,
    input  mem_we,
    input  mem_waddr,
    input  wr_fsm_load,
    input  wr_fsm_req_ack,
    input  waddr
  );
endinterface

// File: rtl/riv_async_fifo_wr_ctrl.sv
// Write-side controller of the async FIFO (wclk domain): write pointer, RAM strobe,
// fill flags, overflow report and the four-phase pointer-transfer handshake.
module riv_async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int AFULL_THRESH = 2**(ADDR_WIDTH-1) - 2
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  riv_async_fifo_wr_ctrl_if.master  io_wr
);

  localparam int                    DEPTH   = 2**(ADDR_WIDTH-1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AFULL_C = ADDR_WIDTH'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH-1:0] ONE_C   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_overflow;
  logic [ADDR_WIDTH-1:0] w_count;
  logic                  w_full;
  logic                  w_afull;
  logic                  w_acc;
  logic                  w_load;
  logic                  w_req;

  // The read pointer is stale, so this count can only overstate the fill level.
  assign w_count = r_waddr - io_wr.raddr_wr;
  assign w_full  = wrst_n & (w_count == DEPTH_C);
  assign w_afull = wrst_n & (w_count >= AFULL_C);
  assign w_acc   = wrst_n & io_wr.wr_en & ~w_full;

  // Write pointer: advances on every accepted write, MSB toggles on wrap
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_waddr <= '0;
    end else if (w_acc) begin
      r_waddr <= r_waddr + ONE_C;
    end else begin
      r_waddr <= r_waddr;
    end
  end

  // Overflow pulse for the cycle after a write was attempted while full
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= io_wr.wr_en & w_full;
    end
  end

  // Handshake state register
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and decoded handshake outputs; load is only issued with req and ack both low
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!io_wr.wr_fsm_recv_ack) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (io_wr.wr_fsm_recv_ack) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (!io_wr.wr_fsm_recv_ack) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign io_wr.mem_we          = w_acc;
  assign io_wr.mem_waddr       = wrst_n ? r_waddr[ADDR_WIDTH-2:0] : '0;
  assign io_wr.waddr           = wrst_n ? r_waddr : '0;
  assign io_wr.wr_count        = wrst_n ? w_count : '0;
  assign io_wr.wr_full         = w_full;
  assign io_wr.wr_almost_full  = w_afull;
  assign io_wr.wr_overflow     = r_overflow & wrst_n;
  assign io_wr.wr_fsm_load     = w_load;
  assign io_wr.wr_fsm_req_ack  = w_req;

endmodule

// File: tb/tb_riv_async_fifo_wr_ctrl.sv
// Bench for riv_async_fifo_wr_ctrl: directed scenarios plus random traffic checked
// against an occupancy model, with a 3-cycle ack loopback standing in for the CDC block.
module tb_riv_async_fifo_wr_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  riv_async_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  riv_async_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .io_wr  (bus)
  );

  // CDC stand-in: ack follows req three edges later; latch captures waddr on load
  logic [2:0]    ack_pipe = 3'b000;
  logic [AW-1:0] cdc_latch = '0;
  logic          ack_force = 1'b0;
  logic          ack_val = 1'b0;
  always @(posedge wclk) begin
    ack_pipe <= {ack_pipe[1:0], bus.wr_fsm_req_ack};
    if (bus.wr_fsm_load) cdc_latch <= bus.waddr;
  end
  assign bus.wr_fsm_recv_ack = ack_force ? ack_val : ack_pipe[2];

  int n_checks = 0;
  int n_err = 0;

  // Reference model: total words written and total words the reader has consumed
  int n_wr = 0;
  int rd_tot = 0;
  bit ovf_prev = 1'b0;
  bit prev_load = 1'b0;
  bit chk_latch = 1'b0;
  int exp_latch = 0;
  int loads = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One wclk cycle: drive inputs, check outputs against the model, advance across the edge
  task automatic cycle(input bit we, input int rd_adv, input bit chk_hs);
    int cnt;
    bit full_e;
    bit acc_e;
    if (!wrst_n) rd_tot = 0;
    else rd_tot = rd_tot + rd_adv;
    if (rd_tot > n_wr) rd_tot = n_wr;
    bus.wr_en    = we;
    bus.raddr_wr = AW'(rd_tot % 16);
    #1;
    cnt    = n_wr - rd_tot;
    full_e = wrst_n && (cnt == DEPTH);
    acc_e  = wrst_n && we && !full_e;
    check("mem_we",    32'(bus.mem_we),         32'(acc_e));
    check("wr_full",   32'(bus.wr_full),        32'(full_e));
    check("wr_afull",  32'(bus.wr_almost_full), 32'(wrst_n && cnt >= AFT));
    check("wr_count",  32'(bus.wr_count),       wrst_n ? 32'(cnt) : 32'd0);
    check("waddr",     32'(bus.waddr),          wrst_n ? 32'(n_wr % 16) : 32'd0);
    check("mem_waddr", 32'(bus.mem_waddr),      wrst_n ? 32'(n_wr % 8) : 32'd0);
    check("overflow",  32'(bus.wr_overflow),    32'(wrst_n && ovf_prev));
    if (chk_hs && wrst_n) begin
      check("load_excl", 32'(bus.wr_fsm_load & (bus.wr_fsm_req_ack | bus.wr_fsm_recv_ack)), 32'd0);
      if (prev_load) begin
        check("load_1cyc",  32'(bus.wr_fsm_load),    32'd0);
        check("req_after",  32'(bus.wr_fsm_req_ack), 32'd1);
      end
      if (chk_latch) check("cdc_latch", 32'(cdc_latch), 32'(exp_latch));
      chk_latch = 1'b0;
      if (bus.wr_fsm_load) begin
        exp_latch = n_wr % 16;
        chk_latch = 1'b1;
        loads++;
      end
    end else begin
      chk_latch = 1'b0;
    end
    prev_load = wrst_n && bus.wr_fsm_load;
    @(posedge wclk);
    if (!wrst_n) begin
      n_wr = 0;
      ovf_prev = 1'b0;
      prev_load = 1'b0;
    end else begin
      ovf_prev = we && full_e;
      if (acc_e) n_wr++;
    end
    #1;
  endtask

  initial begin
    bit got_req;
    bit we;
    int pw;
    int pr;
    wrst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.raddr_wr = '0;
    #1;

    // Reset for five cycles with wr_en asserted to prove writes are ignored
    for (int i = 0; i < 5; i++) cycle(i[0], 0, 1'b1);
    check("rst_load", 32'(bus.wr_fsm_load), 32'd0);
    check("rst_req",  32'(bus.wr_fsm_req_ack), 32'd0);
    wrst_n = 1'b1;
    #1;
    check("idle_load", 32'(bus.wr_fsm_load), 32'd0);
    cycle(1'b0, 0, 1'b1);
    check("first_load", 32'(bus.wr_fsm_load), 32'd1);
    check("first_noreq", 32'(bus.wr_fsm_req_ack), 32'd0);
    cycle(1'b0, 0, 1'b1);
    check("first_req", 32'(bus.wr_fsm_req_ack), 32'd1);

    // Nine writes into an empty FIFO: eight land, the ninth overflows
    for (int i = 0; i < 9; i++) cycle(1'b1, 0, 1'b1);
    check("t2_ovf",   32'(bus.wr_overflow), 32'd1);
    check("t2_waddr", 32'(bus.waddr), 32'h8);
    check("t2_count", 32'(bus.wr_count), 32'd8);
    cycle(1'b0, 0, 1'b1);

    // Wrap: reader catches up to 4'b1000, eight more writes wrap the pointer
    cycle(1'b0, 8, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 0, 1'b1);
    check("wrap_waddr", 32'(bus.waddr), 32'h0);
    check("wrap_full",  32'(bus.wr_full), 32'd1);
    cycle(1'b0, 1, 1'b1);
    check("wrap_count", 32'(bus.wr_count), 32'd7);
    check("wrap_nfull", 32'(bus.wr_full), 32'd0);

    // Almost-full edges around the threshold
    cycle(1'b0, 16, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 0, 1'b1);
    check("afull_at5", 32'(bus.wr_almost_full), 32'd0);
    cycle(1'b1, 0, 1'b1);
    check("afull_at6", 32'(bus.wr_almost_full), 32'd1);
    cycle(1'b0, 1, 1'b1);
    check("afull_back5", 32'(bus.wr_almost_full), 32'd0);

    // Random traffic in phases that alternately fill and drain
    for (int ph = 0; ph < 12; ph++) begin
      pw = ph[0] ? 85 : 25;
      pr = ph[0] ? 1 : 3;
      for (int i = 0; i < 200; i++) begin
        we = ($urandom_range(0, 99) < pw);
        cycle(we, int'($urandom_range(0, pr)), 1'b1);
      end
    end
    check("loads_seen", 32'(loads > 100), 32'd1);

    // Reset while in REQ with the ack stuck high
    got_req = 1'b0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      if (bus.wr_fsm_req_ack) got_req = 1'b1;
      else cycle(1'b0, 0, 1'b1);
    end
    check("t6_req_seen", 32'(got_req), 32'd1);
    ack_force = 1'b1;
    ack_val = 1'b1;
    wrst_n = 1'b0;
    cycle(1'b0, 0, 1'b0);
    check("t6_req_drop", 32'(bus.wr_fsm_req_ack), 32'd0);
    wrst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 0, 1'b0);
      check("t6_hold_load", 32'(bus.wr_fsm_load), 32'd0);
      check("t6_hold_req",  32'(bus.wr_fsm_req_ack), 32'd0);
    end
    ack_val = 1'b0;
    #1;
    check("t6_idle", 32'(bus.wr_fsm_load), 32'd0);
    cycle(1'b0, 0, 1'b0);
    check("t6_load", 32'(bus.wr_fsm_load), 32'd1);
    cycle(1'b1, 0, 1'b0);
    check("t6_req", 32'(bus.wr_fsm_req_ack), 32'd1);
    ack_force = 1'b0;
    for (int i = 0; i < 40; i++) cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, 1)), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
